display_scanner: RTL

Time-multiplexed seven-segment scan controller that sits directly upstream of the nibble-to-segment decoder. It holds a multi-digit hex value and steps through the digits in turn. For each digit it presents the 4-bit nibble on num, which drives the decoder's num input, and asserts the matching one-hot digit enable. It adds anti-ghosting blank time, tear-free value updates at frame boundaries, and optional leading-zero suppression.

---
 rtl/display_scanner.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment scan controller.
// The controller steps through NDIGITS hex digits. Each digit slot starts with
// BLANK_CYC cycles where every digit is off, followed by the shown period.
// A new value is captured into a pending register and copied into the
// displayed value only at a frame boundary, so one frame never mixes old and
// new digits. Leading zeros can optionally be suppressed.
module display_scanner #(
  parameter int unsigned NDIGITS   = 4,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  input  logic                   lz_en,
  output logic [3:0]             num,
  output logic [NDIGITS-1:0]     digit_en,
  output logic                   frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NDIGITS;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [VAL_W-1:0]   pending, pending_nxt;
  logic [VAL_W-1:0]   active, active_nxt;
  logic               load_seen, load_seen_nxt;
  logic [3:0]         num_nxt;
  logic [NDIGITS-1:0] digit_en_nxt;
  logic               frame_done_nxt;

  logic               slot_end;
  logic               frame_end;
  logic               zero_above;
  logic [NDIGITS-1:0] upper_zero;
  logic [NDIGITS-1:0] supp;

  // State, counters, value registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      active     <= '0;
      load_seen  <= 1'b0;
      num        <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      pending    <= pending_nxt;
      active     <= active_nxt;
      load_seen  <= load_seen_nxt;
      num        <= num_nxt;
      digit_en   <= digit_en_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Next-state, value capture and next output values.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + CNT_W'(1);
    idx_nxt        = idx;
    pending_nxt    = pending;
    active_nxt     = active;
    load_seen_nxt  = load_seen;
    num_nxt        = '0;
    digit_en_nxt   = '0;
    frame_done_nxt = 1'b0;
    zero_above     = 1'b1;
    upper_zero     = '0;
    supp           = '0;

    slot_end  = (cnt == CNT_W'(SCAN_DIV - 1));
    frame_end = slot_end && (idx == IDX_W'(NDIGITS - 1));

    // Slot counter and digit index.
    if (slot_end) begin
      cnt_nxt = '0;
      if (idx == IDX_W'(NDIGITS - 1)) begin
        idx_nxt = '0;
      end else begin
        idx_nxt = idx + IDX_W'(1);
      end
    end

    // Blank/show sequencing within a slot.
    unique case (state)
      BLANK: if (cnt == CNT_W'(BLANK_CYC - 1)) state_nxt = SHOW;
      SHOW:  if (slot_end) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase

    // Capture into pending; promote to active only at the frame boundary.
    // A load on the boundary cycle itself goes straight to active.
    if (load) begin
      pending_nxt   = value;
      load_seen_nxt = 1'b1;
    end
    if (frame_end) begin
      load_seen_nxt  = 1'b0;
      frame_done_nxt = 1'b1;
      if (load) begin
        active_nxt = value;
      end else if (load_seen) begin
        active_nxt = pending;
      end
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
      zero_above    = zero_above && (active_nxt[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_above;
      supp[i]       = lz_en && upper_zero[i] && (i > 0);
    end

    // Nibble select and one-hot enable for the upcoming cycle.
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        num_nxt = active_nxt[4*i +: 4];
        if ((state_nxt == SHOW) && !supp[i]) begin
          digit_en_nxt[i] = 1'b1;
        end
      end
    end
  end

endmodule
